// File: rtl/sqrt_pkg.sv
// Shared constants, state encoding and operand classifier for the sqrt scheduler.
package sqrt_pkg;

    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
    localparam logic [31:0] FP_POS_INF = 32'h7F800000;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT,
        S_RESP  = ST_RESP
    } state_t;

    typedef struct packed {
        logic        bypass;
        logic        err;
        logic [31:0] data;
    } class_t;

    // Operands whose root is known without iterating; order matters (zero before sign).
    function automatic class_t classify(input logic [31:0] a);
        class_t c;
        c = '{bypass: 1'b1, err: 1'b0, data: FP_QNAN};
        if (a[30:0] == 31'd0)
            c.data = a;
        else if (a[30:23] == FP_EXP_MAX && a[22:0] != 23'd0)
            c.data = FP_QNAN;
        else if (a[31])
            c.err = 1'b1;
        else if (a == FP_POS_INF)
            c.data = FP_POS_INF;
        else
            c.bypass = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/sqrt_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after ptr.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    // Scan from farthest to nearest so the closest request to ptr wins last.
    always_comb begin
        grant = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                grant = '0;
                grant[(int'(ptr) + k) % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_scheduler.sv
// Shares one iterative FP32 sqrt core among NUM_REQ requesters with round-robin arbitration,
// special-operand bypass and a done watchdog.
module sqrt_scheduler
    import sqrt_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 4095
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [32*NUM_REQ-1:0] req_a,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 core_start,
    output logic [31:0]          core_a,
    input  logic                 core_done,
    input  logic [31:0]          core_out
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t              state;
    logic [ID_W-1:0]     ptr;
    logic [TW-1:0]       timer;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     gidx;
    logic [ID_W-1:0]     ptr_nxt;
    logic [31:0]         ga;
    class_t              cls;

    rr_arbiter #(.N(NUM_REQ), .PW(ID_W)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) gidx = ID_W'(i);
        ga      = req_a[32*int'(gidx) +: 32];
        cls     = classify(ga);
        ptr_nxt = (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    end

    // Gated by rst_n so every output reads 0 while reset is held.
    assign req_ready = (state == S_IDLE && rst_n) ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ptr        <= '0;
            timer      <= '0;
            core_start <= 1'b0;
            core_a     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (|req_valid) begin
                    rsp_id <= gidx;
                    ptr    <= ptr_nxt;
                    if (cls.bypass) begin
                        rsp_data  <= cls.data;
                        rsp_err   <= cls.err;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        core_a     <= ga;
                        core_start <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    core_start <= 1'b0;
                    timer      <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    if (core_done) begin
                        rsp_data  <= core_out;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        rsp_data  <= FP_QNAN;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_scheduler.sv
// Scoreboard bench for sqrt_scheduler: randomized requesters, behavioural core, reference model.
module tb_sqrt_scheduler;

    localparam int NR  = 4;
    localparam int IDW = 2;
    localparam int TO  = 32;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] PINF = 32'h7F800000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [32*NR-1:0] req_a = '0;
    logic [NR-1:0]   req_ready;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [IDW-1:0]  rsp_id;
    logic [31:0]     rsp_data;
    logic            rsp_err;
    logic            core_start;
    logic [31:0]     core_a;
    logic            core_done;
    logic [31:0]     core_out;
    logic            model_done = 1'b0, manual_done = 1'b0;
    logic [31:0]     model_out = '0;

    assign core_done = model_done | manual_done;
    assign core_out  = model_out;

    sqrt_scheduler #(.NUM_REQ(NR), .ID_W(IDW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .core_start(core_start), .core_a(core_a), .core_done(core_done),
        .core_out(core_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_chk++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    typedef struct {int id; logic [31:0] data; logic err; int lat; int acc;} exp_t;
    typedef struct {logic [31:0] a; int acc;} cexp_t;
    exp_t  sb[$];
    cexp_t cq[$];
    int    order[$];
    int    core_lat = 5;
    int    starts = 0;
    int    mptr = 0;
    bit    rand_rdy = 0, hold_rdy = 0;

    // Stand-in for the iterative core: exact roots for a few squares, a scrambled value otherwise.
    function automatic logic [31:0] core_fn(input logic [31:0] a);
        case (a)
            32'h3F800000: return 32'h3F800000;
            32'h40800000: return 32'h40000000;
            32'h41100000: return 32'h40400000;
            32'h41800000: return 32'h40800000;
            32'h42C80000: return 32'h41200000;
            default:      return a ^ 32'h1234_5678;
        endcase
    endfunction

    // Expected response from the IEEE-754 field rules and the core's behaviour.
    function automatic void ref_model(input logic [31:0] a, input int lat_core,
                                      output bit byp, output logic [31:0] d, output logic e);
        logic       s;
        logic [7:0] ex;
        logic [22:0] m;
        s = a[31]; ex = a[30:23]; m = a[22:0];
        byp = 1; e = 0; d = QNAN;
        if (ex == 0 && m == 0)        d = a;
        else if (ex == 255 && m != 0) d = QNAN;
        else if (s)                   e = 1;
        else if (ex == 255)           d = PINF;
        else begin
            byp = 0;
            if (lat_core < 0) e = 1;
            else              d = core_fn(a);
        end
    endfunction

    int  ccnt;
    bit  cact;
    always @(negedge clk) begin
        model_done = 1'b0;
        if (cact) begin
            if (ccnt == 0) begin
                model_done = 1'b1;
                model_out  = core_fn(core_a);
                cact = 0;
            end else ccnt--;
        end
        if (core_start && core_lat >= 0) begin
            cact = 1;
            ccnt = core_lat;
        end
        if (!rst_n) cact = 0;
    end

    always @(posedge clk) begin
        #1;
        rsp_ready = hold_rdy ? 1'b0 : (rand_rdy ? ($urandom % 3 != 0) : 1'b1);
    end

    bit   in_rsp = 0, prev_start = 0;
    exp_t cur;
    cexp_t ce;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_rsp = 0;
            prev_start = 0;
        end else begin
            if (core_start) begin
                starts++;
                chk("start_one_cycle", prev_start, 0);
                chk("req_ready_while_busy", req_ready, 0);
                if (cq.size() == 0) fail_now("unexpected_start", "core_start with no core operand pending");
                else begin
                    ce = cq.pop_front();
                    chk("core_a", core_a, ce.a);
                    chk("start_cycle", cyc, ce.acc + 1);
                end
            end
            prev_start = core_start;
            if (rsp_valid) begin
                chk("req_ready_in_resp", req_ready, 0);
                if (!in_rsp) begin
                    in_rsp = 1;
                    if (sb.size() == 0) begin
                        fail_now("unexpected_rsp", $sformatf("got id %0d data %h, required none", rsp_id, rsp_data));
                        cur = '{rsp_id, rsp_data, rsp_err, -1, cyc};
                    end else begin
                        cur = sb.pop_front();
                        chk("rsp_id", rsp_id, cur.id);
                        chk("rsp_data", rsp_data, cur.data);
                        chk("rsp_err", rsp_err, cur.err);
                        if (cur.lat >= 0) chk("rsp_latency", cyc - cur.acc, cur.lat);
                    end
                end else begin
                    chk("rsp_id_stable", rsp_id, cur.id);
                    chk("rsp_data_stable", rsp_data, cur.data);
                    chk("rsp_err_stable", rsp_err, cur.err);
                end
                if (rsp_ready) in_rsp = 0;
            end
        end
    end

    task automatic run_batch(input logic [NR-1:0] mask, input logic [31:0] ops [NR], input int budget);
        logic [NR-1:0] acc;
        int gi, eg, n;
        bit byp;
        logic [31:0] d, a;
        logic e;
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) if (mask[i]) req_a[32*i +: 32] = ops[i];
        req_valid = req_valid | mask;
        n = 0;
        while (req_valid != 0 && n < budget) begin
            @(negedge clk);
            n++;
            acc = req_valid & req_ready;
            if (acc != 0) begin
                chk("grant_onehot", $countones(acc), 1);
                gi = 0;
                for (int i = 0; i < NR; i++) if (acc[i]) gi = i;
                eg = -1;
                for (int k = 0; k < NR; k++)
                    if (eg < 0 && req_valid[(mptr + k) % NR]) eg = (mptr + k) % NR;
                chk("grant_idx", gi, eg);
                mptr = (eg + 1) % NR;
                order.push_back(gi);
                a = req_a[32*gi +: 32];
                ref_model(a, core_lat, byp, d, e);
                sb.push_back('{gi, d, e, byp ? 1 : (core_lat < 0 ? TO + 2 : core_lat + 3), cyc});
                if (!byp) cq.push_back('{a, cyc});
                @(posedge clk); #1;
                req_valid[gi] = 1'b0;
            end
        end
        if (req_valid != 0) fail_now("grant_timeout", $sformatf("valid %b never granted", req_valid));
        req_valid = '0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while ((sb.size() != 0 || rsp_valid || in_rsp) && n < budget);
        if (sb.size() != 0 || rsp_valid) fail_now("drain_timeout", $sformatf("%0d responses outstanding", sb.size()));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_core_a"}, core_a, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_req_ready"}, req_ready, 0);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1 check_all_zero("reset");
        sb.delete(); cq.delete();
        mptr = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [31:0] ops [NR];
    logic [31:0] pool [12];
    int s0, n;

    initial begin
        pool = '{32'h3F800000, 32'h40800000, 32'h41100000, 32'h41800000, 32'h42C80000, 32'h00000000,
                 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7F800001, 32'hC0800000, 32'h3E000000};
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: plain core operation
        core_lat = 20; s0 = starts;
        ops = '{32'h40800000, 0, 0, 0};
        run_batch(4'b0001, ops, 50); drain(100);
        chk("t1_starts", starts - s0, 1);

        // 2-3: bypass operands never touch the core
        s0 = starts;
        ops = '{0, 32'h00000000, 0, 0};  run_batch(4'b0010, ops, 50); drain(50);
        ops = '{0, 32'h7F800000, 0, 0};  run_batch(4'b0010, ops, 50); drain(50);
        ops = '{0, 0, 32'hC0800000, 0};  run_batch(4'b0100, ops, 50); drain(50);
        chk("t23_starts", starts - s0, 0);

        // 4: all four at once from ptr 0, then wrap
        apply_reset();
        core_lat = 4; order.delete();
        ops = '{32'h3F800000, 32'h40800000, 32'h41100000, 32'h42C80000};
        run_batch(4'b1111, ops, 200); drain(100);
        for (int i = 0; i < 4; i++) chk("t4_order", order[i], i);
        ops = '{32'h3F800000, 0, 32'h41100000, 0};
        run_batch(4'b0101, ops, 200); drain(100);
        chk("t4_wrap_first", order[4], 0);
        chk("t4_wrap_second", order[5], 2);

        // 5: watchdog, late done, then recovery
        core_lat = -1;
        ops = '{0, 0, 0, 32'h41800000}; run_batch(4'b1000, ops, 50); drain(TO + 20);
        @(posedge clk); #1 manual_done = 1'b1;
        @(posedge clk); #1 manual_done = 1'b0;
        repeat (3) @(posedge clk);
        #2 chk("t5_late_done_no_rsp", rsp_valid, 0);
        core_lat = 2;
        ops = '{0, 32'h41800000, 0, 0}; run_batch(4'b0010, ops, 50); drain(50);

        // 6: back-pressure with a waiting requester that later drops out
        hold_rdy = 1; core_lat = 3;
        ops = '{32'h42C80000, 0, 0, 0}; run_batch(4'b0001, ops, 50);
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #2 n++; end
        chk("t6_rsp_seen", rsp_valid, 1);
        req_a[32 +: 32] = 32'h3F800000; req_valid[1] = 1'b1;
        repeat (5) @(negedge clk);
        #1 req_valid[1] = 1'b0;
        hold_rdy = 0; drain(50);
        ops = '{0, 32'h3F800000, 0, 0}; run_batch(4'b0010, ops, 50); drain(50);

        // 6b: reset while waiting on the core
        core_lat = -1;
        ops = '{0, 0, 32'h41100000, 0}; run_batch(4'b0100, ops, 50);
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_all_zero("wait_reset");
        sb.delete(); cq.delete(); mptr = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (TO + 5) begin @(negedge clk); chk("no_rsp_after_reset", rsp_valid, 0); end
        core_lat = 1; s0 = starts;
        ops = '{0, 0, 0, 32'h3F800000}; run_batch(4'b1000, ops, 50); drain(50);
        chk("t6_starts_after_reset", starts - s0, 1);

        // random mix with random back-pressure
        rand_rdy = 1;
        for (int r = 0; r < 40; r++) begin
            core_lat = ($urandom % 10 == 0) ? -1 : int'($urandom_range(0, 8));
            for (int i = 0; i < NR; i++)
                ops[i] = ($urandom % 6 == 0) ? $urandom : pool[$urandom_range(0, 11)];
            run_batch(4'($urandom_range(1, 15)), ops, 2000);
            drain(3000);
        end
        rand_rdy = 0;
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
